// File: rtl/buf_ram_pp_1p_coef_pkg.sv
// Shared definitions for the ping-pong coefficient buffer: pixel width and
// the per-bank ownership state encoding.
package buf_ram_pp_1p_coef_pkg;

    localparam int PIXEL_WIDTH = 8;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    // Ownership step for one bank; only the selected side may move a bank.
    function automatic bank_state_e bank_next(
        input bank_state_e cur,
        input logic        is_wr_bank,
        input logic        is_rd_bank,
        input logic        wr_done_hon,
        input logic        rd_done_hon
    );
        bank_state_e nxt;
        nxt = cur;
        case (cur)
            BANK_EMPTY:    if (is_wr_bank)                nxt = BANK_FILLING;
            BANK_FILLING:  if (is_wr_bank && wr_done_hon) nxt = BANK_FULL;
            BANK_FULL:     if (is_rd_bank)                nxt = BANK_DRAINING;
            BANK_DRAINING: if (is_rd_bank && rd_done_hon) nxt = BANK_EMPTY;
            default:                                      nxt = BANK_EMPTY;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/buf_ram_pp_1p_coef_bank.sv
// One single-port RAM bank behind a plain ce/we/addr/din/dout interface,
// modelling either the ASIC macro (active-low cen/wen) or the FPGA macro (rden/wren).
module buf_ram_pp_1p_coef_bank #(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 192,
    parameter bit FPGA_MODEL = 1'b0
) (
    input  logic              clk,
    input  logic              ce_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] dout_q;

    generate
        if (FPGA_MODEL) begin : g_fpga
            logic rden;
            logic wren;
            assign rden = ce_i & ~we_i;
            assign wren = ce_i & we_i;
            always_ff @(posedge clk) begin
                if (wren) mem[addr_i] <= din_i;
                if (rden) dout_q <= mem[addr_i];
            end
        end else begin : g_asic
            logic cen_n;
            logic wen_n;
            assign cen_n = ~ce_i;
            assign wen_n = ~we_i;
            always_ff @(posedge clk) begin
                if (!cen_n) begin
                    if (!wen_n) mem[addr_i] <= din_i;
                    else        dout_q <= mem[addr_i];
                end
            end
        end
    endgenerate

    assign dout_o = dout_q;

endmodule

// File: rtl/buf_ram_pp_1p_coef.sv
// Ping-pong coefficient buffer: the producer fills one bank while the consumer
// drains the other, with per-bank ownership tracked by a small state machine.
module buf_ram_pp_1p_coef
    import buf_ram_pp_1p_coef_pkg::*;
#(
    parameter int DATA_W     = PIXEL_WIDTH * 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 192,
    parameter bit FPGA_MODEL = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              wr_ready,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              rd_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              addr_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    bank_state_e       state_q [2];
    bank_state_e       state_d [2];
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_valid_q;
    logic              rd_bank_q;
    logic              rd_oob_q;
    logic              addr_err_q;
    logic [DATA_W-1:0] rd_hold_q;
    logic [DATA_W-1:0] rd_fresh;
    logic [DATA_W-1:0] bank_dout [2];

    logic wr_hon, wr_done_hon, rd_hon, rd_done_hon;
    logic wr_in_range, rd_in_range;

    assign wr_ready    = (state_q[wr_sel_q] == BANK_FILLING);
    assign rd_ready    = (state_q[rd_sel_q] == BANK_DRAINING);
    assign wr_hon      = wr_en & wr_ready;
    assign wr_done_hon = wr_done & wr_ready;
    assign rd_hon      = rd_en & rd_ready;
    assign rd_done_hon = rd_done & rd_ready;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = bank_next(state_q[i], wr_sel_q == 1'(i), rd_sel_q == 1'(i),
                                   wr_done_hon, rd_done_hon);
        end
        wr_sel_d = wr_sel_q ^ wr_done_hon;
        rd_sel_d = rd_sel_q ^ rd_done_hon;
    end

    // Out-of-range accesses never reach a bank, so they cannot alias into the RAM.
    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            logic              wr_hit;
            logic              rd_hit;
            logic              ce;
            logic [ADDR_W-1:0] addr;

            assign wr_hit = wr_hon & wr_in_range & (wr_sel_q == 1'(b));
            assign rd_hit = rd_hon & rd_in_range & (rd_sel_q == 1'(b));
            assign ce     = wr_hit | rd_hit;
            assign addr   = wr_hit ? wr_addr : rd_addr;

            buf_ram_pp_1p_coef_bank #(
                .DATA_W     (DATA_W),
                .ADDR_W     (ADDR_W),
                .DEPTH      (DEPTH),
                .FPGA_MODEL (FPGA_MODEL)
            ) u_bank (
                .clk    (clk),
                .ce_i   (ce),
                .we_i   (wr_hit),
                .addr_i (addr),
                .din_i  (wr_data),
                .dout_o (bank_dout[b])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_sel_q   <= 1'b0;
            rd_sel_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_oob_q   <= 1'b0;
            addr_err_q <= 1'b0;
            rd_hold_q  <= '0;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
            wr_sel_q   <= wr_sel_d;
            rd_sel_q   <= rd_sel_d;
            rd_valid_q <= rd_hon;
            rd_bank_q  <= rd_sel_q;
            rd_oob_q   <= ~rd_in_range;
            addr_err_q <= addr_err_q | (wr_hon & ~wr_in_range) | (rd_hon & ~rd_in_range);
            if (rd_valid_q) rd_hold_q <= rd_fresh;
        end
    end

    // The RAM q is already registered; the hold register keeps rd_data stable between reads.
    assign rd_fresh = rd_oob_q ? '0 : bank_dout[rd_bank_q];
    assign rd_data  = rd_valid_q ? rd_fresh : rd_hold_q;
    assign rd_valid = rd_valid_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_buf_ram_pp_1p_coef.sv
// Directed bench for the ping-pong coefficient buffer: fill/drain both banks,
// ignored strobes, out-of-range access and mid-fill reset.
module tb_buf_ram_pp_1p_coef;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 192;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;
    logic              rd_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_done;
    logic              addr_err;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    buf_ram_pp_1p_coef #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .rd_ready (rd_ready),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_done  (rd_done),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_vec(input string tag, input logic [DATA_W-1:0] got,
                             input logic [DATA_W-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic read_word(input int a, input logic [DATA_W-1:0] exp);
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(a);
        tick();
        rd_en   = 1'b0;
        check_vec("rd_valid", {63'd0, rd_valid}, 64'd1);
        check_vec("rd_data", rd_data, exp);
    endtask

    task automatic pulse_done(input logic w, input logic r);
        wr_done = w;
        rd_done = r;
        tick();
        wr_done = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic check_ready(input string tag, input logic exp_wr, input logic exp_rd);
        check_vec({tag, "_wr_ready"}, {63'd0, wr_ready}, {63'd0, exp_wr});
        check_vec({tag, "_rd_ready"}, {63'd0, rd_ready}, {63'd0, exp_rd});
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_done = 1'b0;
        rd_en = 1'b0; rd_addr = '0; rd_done = 1'b0;
        tick();
        tick();
        check_ready("reset", 1'b0, 1'b0);
        check_vec("reset_rd_valid", {63'd0, rd_valid}, 64'd0);
        check_vec("reset_rd_data", rd_data, 64'd0);
        check_vec("reset_addr_err", {63'd0, addr_err}, 64'd0);

        rst = 1'b0;
        tick();
        tick();
        check_ready("idle", 1'b1, 1'b0);
        check_vec("idle_addr_err", {63'd0, addr_err}, 64'd0);

        // Bank 0 fill, hand-off to reader two cycles after wr_done.
        for (int a = 0; a < DEPTH; a++) write_word(a, 64'(a));
        pulse_done(1'b1, 1'b0);
        check_ready("wr_done0", 1'b0, 1'b0);
        tick();
        check_ready("drain0", 1'b1, 1'b1);

        // Concurrent fill of bank 1 and drain of bank 0.
        for (int a = 0; a < DEPTH; a++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = 64'(a + 1000);
            rd_en = 1'b1; rd_addr = ADDR_W'(a);
            tick();
            wr_en = 1'b0; rd_en = 1'b0;
            check_vec("drain0_valid", {63'd0, rd_valid}, 64'd1);
            check_vec("drain0_data", rd_data, 64'(a));
        end
        tick();
        check_vec("hold_valid", {63'd0, rd_valid}, 64'd0);
        check_vec("hold_data", rd_data, 64'd191);

        pulse_done(1'b0, 1'b1);
        check_ready("rd_done0", 1'b1, 1'b0);
        pulse_done(1'b1, 1'b0);
        check_ready("wr_done1", 1'b0, 1'b0);
        tick();
        check_ready("drain1", 1'b1, 1'b1);

        // Both banks full: writer locked out, stray strobes must not land.
        for (int a = 0; a < DEPTH; a++) write_word(a, 64'(a + 2000));
        pulse_done(1'b1, 1'b0);
        check_ready("both_full", 1'b0, 1'b1);
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 64'hDEAD; wr_done = 1'b1;
        tick();
        wr_en = 1'b0; wr_done = 1'b0;
        check_ready("ignored_wr", 1'b0, 1'b1);
        check_vec("ignored_addr_err", {63'd0, addr_err}, 64'd0);
        for (int a = 0; a < DEPTH; a++) read_word(a, 64'(a + 1000));

        pulse_done(1'b0, 1'b1);
        check_ready("rd_done1", 1'b0, 1'b0);
        tick();
        check_ready("refill1", 1'b1, 1'b1);
        read_word(0, 64'd2000);
        read_word(5, 64'd2005);
        read_word(191, 64'd2191);
        write_word(0, 64'd3000);
        write_word(7, 64'd3007);
        write_word(191, 64'd3191);

        // Simultaneous hand-off on both sides.
        pulse_done(1'b1, 1'b1);
        check_ready("both_done", 1'b0, 1'b0);
        tick();
        check_ready("after_both", 1'b1, 1'b1);
        read_word(0, 64'd3000);
        read_word(7, 64'd3007);

        // Out-of-range read returns zero and latches addr_err.
        read_word(250, 64'd0);
        check_vec("rd_oob_addr_err", {63'd0, addr_err}, 64'd1);
        read_word(191, 64'd3191);
        tick();
        check_vec("sticky_addr_err", {63'd0, addr_err}, 64'd1);
        check_vec("hold_data2", rd_data, 64'd3191);

        // Reset in the middle of a fill.
        for (int a = 0; a < 97; a++) write_word(a, 64'(a + 4000));
        wr_en = 1'b1; wr_addr = 8'd97; wr_data = 64'd4097; rst = 1'b1;
        tick();
        wr_en = 1'b0; rst = 1'b0;
        check_ready("mid_rst", 1'b0, 1'b0);
        check_vec("mid_rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check_vec("mid_rst_addr_err", {63'd0, addr_err}, 64'd0);
        check_vec("mid_rst_rd_data", rd_data, 64'd0);
        rd_en = 1'b1; rd_addr = 8'd0;
        tick();
        rd_en = 1'b0;
        check_ready("post_rst", 1'b1, 1'b0);
        check_vec("ignored_rd_valid", {63'd0, rd_valid}, 64'd0);

        // Out-of-range write is dropped but flagged.
        write_word(200, 64'd77);
        check_vec("wr_oob_addr_err", {63'd0, addr_err}, 64'd1);
        check_ready("wr_oob", 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
